// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared helpers for the round-robin arbiter (one-hot decode, wrapping increment).
package rr_arb_pkg;
  function automatic int onehot2idx(input logic [63:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 64; i++) if (oh[i]) idx = idx | i;
    return idx;
  endfunction
  function automatic int inc_wrap(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational first-request-at-or-after-ptr picker.
module rr_priority_picker
  import rr_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     requests_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grants_o,
  output logic [IDX_W-1:0] idx_o
);
  localparam logic [2*N-1:0] ONE = {{(2*N-1){1'b0}}, 1'b1};
  logic [2*N-1:0] dbl, mask, masked, lo;
  // Doubled vector with bits below ptr masked: lowest survivor is the wrapped winner.
  always_comb begin
    dbl = {requests_i, requests_i};
    mask = (ONE << ptr_i) - ONE;
    masked = dbl & ~mask;
    lo = masked & (~masked + ONE);
    grants_o = lo[N-1:0] | lo[2*N-1:N];
    idx_o = IDX_W'(onehot2idx(64'(grants_o)));
  end
endmodule

// File: rtl/round_robin_arbiter_n_requests.sv
// round_robin_arbiter_n_requests: N-way round-robin arbiter with hold/lock bursts.
// Define RR_ARB_MAX_BURST_EN to cap held bursts at MAX_BURST grants.
module round_robin_arbiter_n_requests
  import rr_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int MAX_BURST = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     requests_i,
  input  logic             hold_i,
  output logic [N-1:0]     grants_o,
  output logic             grant_valid_o,
  output logic [IDX_W-1:0] grant_idx_o
);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};
  logic [IDX_W-1:0] ptr_q, ptr_d, owner_idx_q, owner_idx_d, pick_idx;
  logic             owner_valid_q, owner_valid_d, lock, cap;
  logic [N-1:0]     pick_grants;

  rr_priority_picker #(.N(N)) u_pick (
    .requests_i(requests_i),
    .ptr_i     (ptr_q),
    .grants_o  (pick_grants),
    .idx_o     (pick_idx)
  );

`ifdef RR_ARB_MAX_BURST_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0] burst_q, burst_d;
  always_comb begin
    burst_d = !grant_valid_o ? '0 : lock ? burst_q + 1'b1 : CW'(1);
    cap = burst_d == CW'(MAX_BURST);
  end
  always_ff @(posedge clk) burst_q <= rst ? '0 : burst_d;
`else
  logic [31:0] unused_max_burst;
  assign unused_max_burst = 32'(MAX_BURST);
  assign cap = 1'b0;
`endif

  // Outputs are forced low during reset since registers only clear at the edge.
  always_comb begin
    lock = owner_valid_q && requests_i[owner_idx_q];
    grants_o = rst ? '0 : lock ? ONE << owner_idx_q : pick_grants;
    grant_idx_o = rst ? '0 : lock ? owner_idx_q : pick_idx;
    grant_valid_o = |grants_o;
    ptr_d = grant_valid_o ? IDX_W'(inc_wrap(int'(grant_idx_o), N)) : ptr_q;
    owner_idx_d = grant_valid_o ? grant_idx_o : owner_idx_q;
    owner_valid_d = grant_valid_o && hold_i && !cap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      owner_idx_q <= '0;
      owner_valid_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      owner_idx_q <= owner_idx_d;
      owner_valid_q <= owner_valid_d;
    end
  end
endmodule

// File: tb/tb_round_robin_arbiter_n_requests.sv
// tb_round_robin_arbiter_n_requests: directed checks of rotation, idle retention, lock and reset.
module tb_round_robin_arbiter_n_requests;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] requests = 4'b0000;
  logic       hold = 1'b0;
  logic [3:0] grants;
  logic       grant_valid;
  logic [1:0] grant_idx;
  int checks = 0;
  int errors = 0;

  round_robin_arbiter_n_requests #(.N(4), .MAX_BURST(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .requests_i   (requests),
    .hold_i       (hold),
    .grants_o     (grants),
    .grant_valid_o(grant_valid),
    .grant_idx_o  (grant_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [3:0] eg, input logic [1:0] ei, input string tag);
    @(negedge clk);
    checks++;
    assert (grants === eg && grant_valid === (|eg) && grant_idx === ei)
    else begin
      errors++;
      $error("FAIL %s: grants=%b valid=%b idx=%0d, expected grants=%b valid=%b idx=%0d",
             tag, grants, grant_valid, grant_idx, eg, |eg, ei);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    chk(4'b0000, 2'd0, "in_reset");
    rst = 1'b0;
  endtask

  initial begin
    requests = 4'b1111;
    chk(4'b0000, 2'd0, "reset_outputs");
    rst = 1'b0;
    chk(4'b0001, 2'd0, "rot0");
    chk(4'b0010, 2'd1, "rot1");
    chk(4'b0100, 2'd2, "rot2");
    chk(4'b1000, 2'd3, "rot3");
    chk(4'b0001, 2'd0, "rot_wrap");

    do_reset();
    requests = 4'b1010;
    chk(4'b0010, 2'd1, "alt0");
    chk(4'b1000, 2'd3, "alt1");
    chk(4'b0010, 2'd1, "alt2");
    chk(4'b1000, 2'd3, "alt3");

    do_reset();
    requests = 4'b0010;
    chk(4'b0010, 2'd1, "idle_pre");
    requests = 4'b0000;
    chk(4'b0000, 2'd0, "idle_none");
    requests = 4'b1111;
    chk(4'b0100, 2'd2, "idle_retained_ptr");

    do_reset();
    hold = 1'b1;
    requests = 4'b0011;
    for (int i = 0; i < 5; i++) chk(4'b0001, 2'd0, "lock_hold");
    requests = 4'b0010;
    chk(4'b0010, 2'd1, "lock_owner_drops");

    do_reset();
    requests = 4'b0011;
    chk(4'b0001, 2'd0, "hold_first");
    hold = 1'b0;
    chk(4'b0001, 2'd0, "hold_last_locked");
    chk(4'b0010, 2'd1, "hold_released");

    do_reset();
    requests = 4'b1111;
    chk(4'b0001, 2'd0, "mid_rot0");
    chk(4'b0010, 2'd1, "mid_rot1");
    chk(4'b0100, 2'd2, "mid_rot2");
    do_reset();
    chk(4'b0001, 2'd0, "post_reset_lowest");

    hold = 1'b1;
    requests = 4'b0100;
    chk(4'b0100, 2'd2, "lock_before_reset");
    do_reset();
    hold = 1'b0;
    requests = 4'b1111;
    chk(4'b0001, 2'd0, "reset_clears_lock");

`ifdef RR_ARB_MAX_BURST_EN
    do_reset();
    hold = 1'b1;
    requests = 4'b0011;
    chk(4'b0001, 2'd0, "burst0");
    chk(4'b0001, 2'd0, "burst1");
    chk(4'b0001, 2'd0, "burst2");
    chk(4'b0010, 2'd1, "burst3");
    chk(4'b0010, 2'd1, "burst4");
    chk(4'b0010, 2'd1, "burst5");
    chk(4'b0001, 2'd0, "burst6");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/round_robin_arbiter_n_requests.md
Name: round_robin_arbiter_n_requests

Overview:
Parametrised N-requester round-robin arbiter, successor to the 2-request arbiter used in the sequential-basics blocks. It issues a zero-latency one-hot grant and keeps a registered rotating priority pointer. It adds a hold/lock mechanism so a grantee can keep the grant for consecutive cycles (bursts). It sits in front of any shared resource (bus, memory port, FIFO write side) that is contended by N clients.

Parameters:
N, 4, number of requesters; legal range N >= 2.
MAX_BURST, 4, maximum consecutive held grants to one owner; used only with RR_ARB_MAX_BURST_EN; legal range >= 1.
IDX_W (localparam), $clog2(N), width of the grant index.

Ports:
clk  input  1  clock, all state on posedge.
rst  input  1  synchronous, active-high reset.
requests  input  N  request vector; bit i = requester i wants the resource this cycle.
hold  input  1  current grantee asks to keep the grant next cycle; sampled only when grant_valid=1.
grants  output  N  one-hot grant, or all-zero when no grant.
grant_valid  output  1  OR of grants.
grant_idx  output  IDX_W  binary index of the granted requester; 0 when grant_valid=0.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); polarity and synchronicity are fixed.
- State registers:
  - ptr (IDX_W): highest-priority index. Resets to 0.
  - owner_valid (1): resets to 0.
  - owner_idx (IDX_W): resets to 0.
- Outputs while rst=1: grants=0, grant_valid=0, grant_idx=0, regardless of requests.
- Grant is combinational from requests and registered state, with zero cycle latency.
- Lock path: if owner_valid && requests[owner_idx], then grant owner_idx. The pointer is ignored.
- Arbitration path (otherwise): scan indices ptr, ptr+1, ..., N-1, 0, ..., ptr-1. Grant the first index with its request set. All-zero requests give no grant.
- At most one grants bit is set. grant_idx is consistent with grants every cycle.
- Register update at posedge when not in reset:
  - grant_valid=1: ptr <= (grant_idx+1) mod N; owner_idx <= grant_idx; owner_valid <= hold.
  - grant_valid=0: ptr and owner_idx are unchanged; owner_valid <= 0.
- Wrap-around: (N-1)+1 gives 0. N need not be a power of two, so the modulo is explicit.
- ptr is retained across idle cycles. After an idle cycle, priority does not restart at requester 0.
- Lock release:
  - The owner drops its request: the lock is ignored that cycle and arbitration resumes from ptr (= owner+1).
  - hold=0 while granted: the next cycle arbitrates normally.
- Simultaneous full requests with hold=0 give a strict rotation 0,1,...,N-1,0.
- Reset mid-operation clears the lock and the pointer. The first post-reset grant goes to the lowest requesting index.

Optional Feature:
Macro RR_ARB_MAX_BURST_EN.
- Defined: adds a burst counter, width $clog2(MAX_BURST+1), reset to 0.
  - A fresh (arbitration-path) grant sets the counter to 1.
  - A lock-path grant increments it.
  - When the current grant brings the counter to MAX_BURST, owner_valid <= 0 regardless of hold, and ptr advances as normal. The counter clears when grant_valid=0.
- Undefined: no counter. hold can keep the grant indefinitely while the owner keeps requesting. MAX_BURST is unused.

Decomposition:
- Package rr_arb_pkg holds shared helpers: a function converting one-hot to index, and an index increment-with-wrap function parametrised on N.
- One natural sub-module, rr_priority_picker: purely combinational. It takes requests and ptr and returns one-hot grants plus index, using a double-width masked-priority scan.
- The top level holds the lock mux, the registers and the optional burst counter.

Test Plan:
1. N=4, hold=0, requests=1111 held from reset release -> grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
2. N=4, hold=0, requests=1010 from reset -> grants 0010, 1000, 0010, 1000; grant_idx 1, 3, 1, 3.
3. Idle retention: requests=0010 for one cycle (grant 0010), then 0000 (grants 0000, grant_valid=0), then 1111 -> grant 0100.
4. Lock: N=4, hold=1, requests=0011 for 5 cycles -> grants 0001 every cycle. Then requests=0010 -> grant 0010 the same cycle.
5. Reset mid-operation: during rotation at grant 0100, assert rst for 1 cycle -> outputs 0 that cycle. With requests=1111 afterwards -> grant 0001.
6. RR_ARB_MAX_BURST_EN, MAX_BURST=3, hold=1, requests=0011 -> grants 0001, 0001, 0001, 0010, 0010, 0010, 0001.
